// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: memory_unit function codes,
// default widths and the arbiter FSM state encodings.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;

    localparam logic [1:0] GET_CONTENTS = 2'd0;
    localparam logic [1:0] SET_CONTENTS = 2'd1;
    localparam logic [1:0] GET_FREE     = 2'd2;

    localparam logic [2:0] ARB_IDLE    = 3'd0;
    localparam logic [2:0] ARB_ISSUE   = 3'd1;
    localparam logic [2:0] ARB_BUSY    = 3'd2;
    localparam logic [2:0] ARB_GC_HOLD = 3'd3;
    localparam logic [2:0] ARB_GC_RUN  = 3'd4;

endpackage

// File: rtl/mem_arbiter_rr_priority_pick.sv
// Round-robin picker: first asserted request found when scanning upward from
// the slot after ptr, wrapping at NUM_REQ. Purely combinational.
module mem_arbiter_rr_priority_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    // Rotating first-one search; the hit flag keeps the scan branch-free
    always_comb begin
        int raw;
        int cand;
        logic hit;
        any   = 1'b0;
        grant = '0;
        idx   = '0;
        raw   = 0;
        cand  = 0;
        hit   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            raw  = int'(ptr) + i;
            cand = (raw >= NUM_REQ) ? raw - NUM_REQ : raw;
            hit  = !any && req[IDX_W'(cand)];
            grant[IDX_W'(cand)] = grant[IDX_W'(cand)] | hit;
            idx  = hit ? IDX_W'(cand) : idx;
            any  = any | hit;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto the single
// memory_unit command port, including the GC handshake and GET_FREE replay.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_func,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr1,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr2,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_done,
    output logic [DATA_W-1:0]         rsp_data1,
    output logic [DATA_W-1:0]         rsp_data2,
    output logic [ADDR_W-1:0]         rsp_free_addr,
    input  logic                      gc_allow,
    output logic                      gc_busy,
    output logic                      gc_root_valid,
    output logic [ADDR_W-1:0]         gc_new_root,
    output logic [1:0]                mem_func,
    output logic                      mem_execute,
    output logic [ADDR_W-1:0]         mem_addr1,
    output logic [ADDR_W-1:0]         mem_addr2,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_gc_ready,
    input  logic                      mem_is_ready,
    input  logic                      mem_gc,
    input  logic [DATA_W-1:0]         mem_rdata1,
    input  logic [DATA_W-1:0]         mem_rdata2,
    input  logic [ADDR_W-1:0]         mem_free_addr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [2:0]         state_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   grant_idx_r;
    logic [NUM_REQ-1:0] grant_oh_r;
    logic               replay_r;

    logic               pick_any_s;
    logic [NUM_REQ-1:0] pick_oh_s;
    logic [IDX_W-1:0]   pick_idx_s;

    logic [1:0]         func_arr_s  [NUM_REQ];
    logic [ADDR_W-1:0]  addr1_arr_s [NUM_REQ];
    logic [ADDR_W-1:0]  addr2_arr_s [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr_s [NUM_REQ];

    // Unpack the flat requester buses into per-requester fields
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            func_arr_s[i]  = req_func[i*2 +: 2];
            addr1_arr_s[i] = req_addr1[i*ADDR_W +: ADDR_W];
            addr2_arr_s[i] = req_addr2[i*ADDR_W +: ADDR_W];
            wdata_arr_s[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    mem_arbiter_rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_r),
        .any   (pick_any_s),
        .grant (pick_oh_s),
        .idx   (pick_idx_s)
    );

    // Transaction FSM; every output is a register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ARB_IDLE;
            ptr_r         <= IDX_W'(NUM_REQ - 1);
            grant_idx_r   <= '0;
            grant_oh_r    <= '0;
            replay_r      <= 1'b0;
            rsp_done      <= '0;
            rsp_data1     <= '0;
            rsp_data2     <= '0;
            rsp_free_addr <= '0;
            gc_busy       <= 1'b0;
            gc_root_valid <= 1'b0;
            gc_new_root   <= '0;
            mem_func      <= 2'd0;
            mem_execute   <= 1'b0;
            mem_addr1     <= '0;
            mem_addr2     <= '0;
            mem_wdata     <= '0;
            mem_gc_ready  <= 1'b0;
        end else begin
            rsp_done      <= '0;
            gc_root_valid <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    // A collection started by someone else is parked without a grant
                    if (mem_gc) begin
                        gc_busy  <= 1'b1;
                        replay_r <= 1'b0;
                        state_r  <= ARB_GC_HOLD;
                    end else if (mem_is_ready && pick_any_s) begin
                        grant_oh_r  <= pick_oh_s;
                        grant_idx_r <= pick_idx_s;
                        mem_func    <= func_arr_s[pick_idx_s];
                        mem_addr1   <= addr1_arr_s[pick_idx_s];
                        mem_addr2   <= addr2_arr_s[pick_idx_s];
                        mem_wdata   <= wdata_arr_s[pick_idx_s];
                        mem_execute <= 1'b1;
                        state_r     <= ARB_ISSUE;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    mem_execute <= 1'b0;
                    state_r     <= ARB_BUSY;
                end
                ARB_BUSY: begin
                    if (mem_is_ready) begin
                        if (mem_func == GET_FREE && mem_gc) begin
                            gc_busy  <= 1'b1;
                            replay_r <= 1'b1;
                            state_r  <= ARB_GC_HOLD;
                        end else begin
                            rsp_data1     <= mem_rdata1;
                            rsp_data2     <= mem_rdata2;
                            rsp_free_addr <= mem_free_addr;
                            rsp_done      <= grant_oh_r;
                            ptr_r         <= grant_idx_r;
                            state_r       <= ARB_IDLE;
                        end
                    end else begin
                        state_r <= ARB_BUSY;
                    end
                end
                ARB_GC_HOLD: begin
                    if (gc_allow) begin
                        mem_gc_ready <= 1'b1;
                        state_r      <= ARB_GC_RUN;
                    end else begin
                        state_r <= ARB_GC_HOLD;
                    end
                end
                ARB_GC_RUN: begin
                    // Memory reports the relocated root on read_data1 when GC ends
                    if (!mem_gc && mem_is_ready) begin
                        gc_new_root   <= mem_rdata1[ADDR_W-1:0];
                        gc_root_valid <= 1'b1;
                        mem_gc_ready  <= 1'b0;
                        gc_busy       <= 1'b0;
                        if (replay_r) begin
                            mem_execute <= 1'b1;
                            state_r     <= ARB_ISSUE;
                        end else begin
                            state_r <= ARB_IDLE;
                        end
                    end else begin
                        state_r <= ARB_GC_RUN;
                    end
                end
                default: begin
                    mem_execute  <= 1'b0;
                    mem_gc_ready <= 1'b0;
                    gc_busy      <= 1'b0;
                    state_r      <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
